// File: rtl/alu_arbiter_pkg.sv
// Shared ALU operation encodings for the EX-stage ALU and its arbiter.
package alu_arbiter_pkg;

  localparam int unsigned AluSelWidth = 6;

  localparam logic [AluSelWidth-1:0] ALU_ADD  = 6'd0;
  localparam logic [AluSelWidth-1:0] ALU_SUB  = 6'd1;
  localparam logic [AluSelWidth-1:0] ALU_AND  = 6'd2;
  localparam logic [AluSelWidth-1:0] ALU_OR   = 6'd3;
  localparam logic [AluSelWidth-1:0] ALU_XOR  = 6'd4;
  localparam logic [AluSelWidth-1:0] ALU_SLL  = 6'd5;
  localparam logic [AluSelWidth-1:0] ALU_SRL  = 6'd6;
  localparam logic [AluSelWidth-1:0] ALU_SRA  = 6'd7;
  localparam logic [AluSelWidth-1:0] ALU_SLT  = 6'd8;
  localparam logic [AluSelWidth-1:0] ALU_SLTU = 6'd9;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; owns the priority pointer.
module rr_arbiter2 (
  input  logic CLK,
  input  logic RESET,
  input  logic elig_0,
  input  logic elig_1,
  output logic grant_0,
  output logic grant_1
);

  logic pri_q, pri_d;

  // One-hot grant; the pointer only breaks ties, and reset suppresses all grants.
  always_comb begin
    grant_0 = RESET && elig_0 && (!elig_1 || !pri_q);
    grant_1 = RESET && elig_1 && (!elig_0 || pri_q);
    pri_d   = pri_q;
    if (grant_0) begin
      pri_d = 1'b1;
    end else if (grant_1) begin
      pri_d = 1'b0;
    end
  end

  // Pointer register: favour the port that was not just served.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the main ALU-op path (port 0) and the
// branch/address path (port 1), with a one-deep response register per port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEL_WIDTH = 6
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ_VALID_0,
  output logic                 REQ_READY_0,
  input  logic [WIDTH-1:0]     REQ_DATA1_0,
  input  logic [WIDTH-1:0]     REQ_DATA2_0,
  input  logic [SEL_WIDTH-1:0] REQ_SELECT_0,
  input  logic                 REQ_VALID_1,
  output logic                 REQ_READY_1,
  input  logic [WIDTH-1:0]     REQ_DATA1_1,
  input  logic [WIDTH-1:0]     REQ_DATA2_1,
  input  logic [SEL_WIDTH-1:0] REQ_SELECT_1,
  output logic                 RSP_VALID_0,
  input  logic                 RSP_READY_0,
  output logic [WIDTH-1:0]     RSP_RESULT_0,
  output logic                 RSP_VALID_1,
  input  logic                 RSP_READY_1,
  output logic [WIDTH-1:0]     RSP_RESULT_1,
  output logic [WIDTH-1:0]     ALU_DATA1,
  output logic [WIDTH-1:0]     ALU_DATA2,
  output logic [SEL_WIDTH-1:0] ALU_SELECT,
  input  logic [WIDTH-1:0]     ALU_RESULT
);

  logic elig_0, elig_1;
  logic grant_0, grant_1;
  logic             vld_0_q, vld_0_d, vld_1_q, vld_1_d;
  logic [WIDTH-1:0] res_0_q, res_0_d, res_1_q, res_1_d;

  // A slot is free when empty or being drained this cycle.
  always_comb begin
    elig_0 = REQ_VALID_0 && (!vld_0_q || RSP_READY_0);
    elig_1 = REQ_VALID_1 && (!vld_1_q || RSP_READY_1);
  end

  rr_arbiter2 u_arb (
    .CLK     (CLK),
    .RESET   (RESET),
    .elig_0  (elig_0),
    .elig_1  (elig_1),
    .grant_0 (grant_0),
    .grant_1 (grant_1)
  );

  // ALU operand mux; idle drives ADD 0+0 so the ALU never sees X.
  always_comb begin
    ALU_DATA1  = '0;
    ALU_DATA2  = '0;
    ALU_SELECT = SEL_WIDTH'(ALU_ADD);
    if (grant_0) begin
      ALU_DATA1  = REQ_DATA1_0;
      ALU_DATA2  = REQ_DATA2_0;
      ALU_SELECT = REQ_SELECT_0;
    end else if (grant_1) begin
      ALU_DATA1  = REQ_DATA1_1;
      ALU_DATA2  = REQ_DATA2_1;
      ALU_SELECT = REQ_SELECT_1;
    end
  end

  // Response next-state: load on grant, clear valid on consume, else hold.
  always_comb begin
    vld_0_d = vld_0_q;
    res_0_d = res_0_q;
    vld_1_d = vld_1_q;
    res_1_d = res_1_q;
    if (grant_0) begin
      vld_0_d = 1'b1;
      res_0_d = ALU_RESULT;
    end else if (RSP_READY_0) begin
      vld_0_d = 1'b0;
    end
    if (grant_1) begin
      vld_1_d = 1'b1;
      res_1_d = ALU_RESULT;
    end else if (RSP_READY_1) begin
      vld_1_d = 1'b0;
    end
  end

  // Response registers; reset discards anything in flight.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vld_0_q <= 1'b0;
      res_0_q <= '0;
      vld_1_q <= 1'b0;
      res_1_q <= '0;
    end else begin
      vld_0_q <= vld_0_d;
      res_0_q <= res_0_d;
      vld_1_q <= vld_1_d;
      res_1_q <= res_1_d;
    end
  end

  assign REQ_READY_0  = grant_0;
  assign REQ_READY_1  = grant_1;
  assign RSP_VALID_0  = vld_0_q;
  assign RSP_RESULT_0 = res_0_q;
  assign RSP_VALID_1  = vld_1_q;
  assign RSP_RESULT_1 = res_1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to ALU_*.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned S = 6;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         REQ_VALID_0, REQ_VALID_1;
  logic         REQ_READY_0, REQ_READY_1;
  logic [W-1:0] REQ_DATA1_0, REQ_DATA2_0, REQ_DATA1_1, REQ_DATA2_1;
  logic [S-1:0] REQ_SELECT_0, REQ_SELECT_1;
  logic         RSP_VALID_0, RSP_VALID_1;
  logic         RSP_READY_0, RSP_READY_1;
  logic [W-1:0] RSP_RESULT_0, RSP_RESULT_1;
  logic [W-1:0] ALU_DATA1, ALU_DATA2, ALU_RESULT;
  logic [S-1:0] ALU_SELECT;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(W), .SEL_WIDTH(S)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQ_VALID_0  (REQ_VALID_0),
    .REQ_READY_0  (REQ_READY_0),
    .REQ_DATA1_0  (REQ_DATA1_0),
    .REQ_DATA2_0  (REQ_DATA2_0),
    .REQ_SELECT_0 (REQ_SELECT_0),
    .REQ_VALID_1  (REQ_VALID_1),
    .REQ_READY_1  (REQ_READY_1),
    .REQ_DATA1_1  (REQ_DATA1_1),
    .REQ_DATA2_1  (REQ_DATA2_1),
    .REQ_SELECT_1 (REQ_SELECT_1),
    .RSP_VALID_0  (RSP_VALID_0),
    .RSP_READY_0  (RSP_READY_0),
    .RSP_RESULT_0 (RSP_RESULT_0),
    .RSP_VALID_1  (RSP_VALID_1),
    .RSP_READY_1  (RSP_READY_1),
    .RSP_RESULT_1 (RSP_RESULT_1),
    .ALU_DATA1    (ALU_DATA1),
    .ALU_DATA2    (ALU_DATA2),
    .ALU_SELECT   (ALU_SELECT),
    .ALU_RESULT   (ALU_RESULT)
  );

  // External ALU model.
  always_comb begin
    ALU_RESULT = '0;
    case (ALU_SELECT)
      ALU_ADD:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      ALU_SUB:  ALU_RESULT = ALU_DATA1 - ALU_DATA2;
      ALU_AND:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      ALU_OR:   ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      ALU_XOR:  ALU_RESULT = ALU_DATA1 ^ ALU_DATA2;
      default:  ALU_RESULT = '0;
    endcase
  end

  task automatic set0(input logic v, input logic [S-1:0] sel, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    REQ_VALID_0 = v; REQ_SELECT_0 = sel; REQ_DATA1_0 = a; REQ_DATA2_0 = b;
  endtask

  task automatic set1(input logic v, input logic [S-1:0] sel, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    REQ_VALID_1 = v; REQ_SELECT_1 = sel; REQ_DATA1_1 = a; REQ_DATA2_1 = b;
  endtask

  // Idle one cycle with both consumers ready so every slot drains.
  task automatic drain();
    set0(1'b0, ALU_ADD, 0, 0);
    set1(1'b0, ALU_ADD, 0, 0);
    RSP_READY_0 = 1'b1; RSP_READY_1 = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    set0(1'b1, ALU_ADD, 1, 2);
    set1(1'b1, ALU_ADD, 4, 4);
    RSP_READY_0 = 1'b1; RSP_READY_1 = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    total++;
    if ({REQ_READY_0, REQ_READY_1} !== 2'b00)
      $display("FAIL reset_req_ready got %b want 00", {REQ_READY_0, REQ_READY_1});
    else passed++;
    total++;
    if ({RSP_VALID_0, RSP_VALID_1} !== 2'b00)
      $display("FAIL reset_rsp_valid got %b want 00", {RSP_VALID_0, RSP_VALID_1});
    else passed++;
    total++;
    if (ALU_DATA1 !== 0) $display("FAIL reset_alu_data1 got %0d want 0", ALU_DATA1);
    else passed++;
    RESET = 1'b1;
    #1;
    total++;
    if ({REQ_READY_0, REQ_READY_1} !== 2'b10)
      $display("FAIL reset_first_grant got %b want 10", {REQ_READY_0, REQ_READY_1});
    else passed++;
    @(negedge CLK);
    total++;
    if (RSP_VALID_0 !== 1'b1 || RSP_RESULT_0 !== 3)
      $display("FAIL reset_first_result got %b/%0d want 1/3", RSP_VALID_0, RSP_RESULT_0);
    else passed++;
    drain();
    drain();
  endtask

  task automatic test_single();
    set0(1'b1, ALU_ADD, 5, 10);
    RSP_READY_0 = 1'b1;
    #1;
    total++;
    if (REQ_READY_0 !== 1'b1) $display("FAIL single_ready got %b want 1", REQ_READY_0);
    else passed++;
    @(negedge CLK);
    set0(1'b0, ALU_ADD, 0, 0);
    total++;
    if (RSP_VALID_0 !== 1'b1 || RSP_RESULT_0 !== 15)
      $display("FAIL single_result got %b/%0d want 1/15", RSP_VALID_0, RSP_RESULT_0);
    else passed++;
    total++;
    if (RSP_VALID_1 !== 1'b0 || RSP_RESULT_1 !== 0 || REQ_READY_1 !== 1'b0)
      $display("FAIL single_port1_idle got %b/%0d/%b want 0/0/0",
               RSP_VALID_1, RSP_RESULT_1, REQ_READY_1);
    else passed++;
    drain();
    // Port 1 alone, which also returns the pointer to port 0.
    set1(1'b1, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_00FF);
    @(negedge CLK);
    set1(1'b0, ALU_ADD, 0, 0);
    total++;
    if (RSP_VALID_1 !== 1'b1 || RSP_RESULT_1 !== 32'hFF00_00FF)
      $display("FAIL single_port1_xor got %b/%h want 1/ff0000ff", RSP_VALID_1, RSP_RESULT_1);
    else passed++;
    drain();
  endtask

  task automatic test_contention();
    set0(1'b1, ALU_SUB, 30, 10);
    set1(1'b1, ALU_ADD, 7, 8);
    RSP_READY_0 = 1'b1; RSP_READY_1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if ({REQ_READY_0, REQ_READY_1} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_grant[%0d] got %b want %b", c, {REQ_READY_0, REQ_READY_1},
                 (c % 2 == 0) ? 2'b10 : 2'b01);
      else passed++;
      @(negedge CLK);
      total++;
      if (c % 2 == 0) begin
        if (RSP_VALID_0 !== 1'b1 || RSP_RESULT_0 !== 20 || RSP_VALID_1 !== 1'b0)
          $display("FAIL rr_rsp[%0d] got v0=%b r0=%0d v1=%b want 1/20/0", c,
                   RSP_VALID_0, RSP_RESULT_0, RSP_VALID_1);
        else passed++;
      end else begin
        if (RSP_VALID_1 !== 1'b1 || RSP_RESULT_1 !== 15 || RSP_VALID_0 !== 1'b0)
          $display("FAIL rr_rsp[%0d] got v1=%b r1=%0d v0=%b want 1/15/0", c,
                   RSP_VALID_1, RSP_RESULT_1, RSP_VALID_0);
        else passed++;
      end
    end
    drain();
  endtask

  task automatic test_back_pressure();
    set1(1'b1, ALU_ADD, 3, 4);
    RSP_READY_1 = 1'b0;
    @(negedge CLK);
    set1(1'b1, ALU_ADD, 9, 9);
    RSP_READY_0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, ALU_ADD, 100, i);
      #1;
      total++;
      if ({REQ_READY_0, REQ_READY_1} !== 2'b10)
        $display("FAIL bp_grant[%0d] got %b want 10", i, {REQ_READY_0, REQ_READY_1});
      else passed++;
      @(negedge CLK);
      total++;
      if (RSP_VALID_1 !== 1'b1 || RSP_RESULT_1 !== 7 || RSP_RESULT_0 !== 100 + i)
        $display("FAIL bp_hold[%0d] got v1=%b r1=%0d r0=%0d want 1/7/%0d", i,
                 RSP_VALID_1, RSP_RESULT_1, RSP_RESULT_0, 100 + i);
      else passed++;
    end
    RSP_READY_1 = 1'b1;
    #1;
    total++;
    if ({REQ_READY_0, REQ_READY_1} !== 2'b01)
      $display("FAIL bp_release_grant got %b want 01", {REQ_READY_0, REQ_READY_1});
    else passed++;
    @(negedge CLK);
    total++;
    if (RSP_VALID_1 !== 1'b1 || RSP_RESULT_1 !== 18 || RSP_VALID_0 !== 1'b0)
      $display("FAIL bp_release_rsp got v1=%b r1=%0d v0=%b want 1/18/0",
               RSP_VALID_1, RSP_RESULT_1, RSP_VALID_0);
    else passed++;
    drain();
  endtask

  task automatic test_back_to_back();
    RSP_READY_0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, ALU_ADD, i, 1);
      #1;
      total++;
      if (REQ_READY_0 !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, REQ_READY_0);
      else passed++;
      @(negedge CLK);
      total++;
      if (RSP_VALID_0 !== 1'b1 || RSP_RESULT_0 !== i + 1)
        $display("FAIL b2b_result[%0d] got %b/%0d want 1/%0d", i, RSP_VALID_0, RSP_RESULT_0,
                 i + 1);
      else passed++;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set0(1'b1, ALU_ADD, 7, 8);
    RSP_READY_0 = 1'b0;
    @(negedge CLK);
    set0(1'b0, ALU_ADD, 0, 0);
    total++;
    if (RSP_VALID_0 !== 1'b1 || RSP_RESULT_0 !== 15)
      $display("FAIL mid_preload got %b/%0d want 1/15", RSP_VALID_0, RSP_RESULT_0);
    else passed++;
    RESET = 1'b0;
    set1(1'b1, ALU_ADD, 1, 1);
    @(negedge CLK);
    total++;
    if (RSP_VALID_0 !== 1'b0 || RSP_RESULT_0 !== 0 || RSP_VALID_1 !== 1'b0)
      $display("FAIL mid_cleared got v0=%b r0=%0d v1=%b want 0/0/0",
               RSP_VALID_0, RSP_RESULT_0, RSP_VALID_1);
    else passed++;
    RESET = 1'b1;
    set0(1'b1, ALU_ADD, 2, 2);
    #1;
    total++;
    if ({REQ_READY_0, REQ_READY_1} !== 2'b10)
      $display("FAIL mid_pri_reset got %b want 10", {REQ_READY_0, REQ_READY_1});
    else passed++;
    @(negedge CLK);
    drain();
  endtask

  initial begin
    RESET = 1'b0;
    set0(1'b0, ALU_ADD, 0, 0);
    set1(1'b0, ALU_ADD, 0, 0);
    RSP_READY_0 = 1'b0; RSP_READY_1 = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters in the EX stage: port 0 is the main ALU-op path and port 1 is the branch/address-compute path.
- Each port uses a valid/ready request handshake and a valid/ready response handshake.
- The block drives the ALU inputs from the granted requester and captures the ALU result into a per-port response register.
- Arbitration is round-robin when both ports contend, so neither path starves under back-to-back contention.

Parameters:
- WIDTH, 32, data width of operands and result.
- SEL_WIDTH, 6, width of the ALU operation select.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- REQ_VALID_0 / REQ_VALID_1  input  1  requester n presents an operation.
- REQ_READY_0 / REQ_READY_1  output  1  operation on port n accepted this cycle (combinational grant).
- REQ_DATA1_0 / REQ_DATA1_1  input  WIDTH  operand A.
- REQ_DATA2_0 / REQ_DATA2_1  input  WIDTH  operand B.
- REQ_SELECT_0 / REQ_SELECT_1  input  SEL_WIDTH  ALU operation.
- RSP_VALID_0 / RSP_VALID_1  output  1  response register n holds a result.
- RSP_READY_0 / RSP_READY_1  input  1  requester n consumes the result this cycle.
- RSP_RESULT_0 / RSP_RESULT_1  output  WIDTH  captured result.
- ALU_DATA1  output  WIDTH  to ALU DATA1.
- ALU_DATA2  output  WIDTH  to ALU DATA2.
- ALU_SELECT  output  SEL_WIDTH  to ALU SELECT.
- ALU_RESULT  input  WIDTH  from ALU RESULT.

Behaviour:
- Reset: on a rising CLK edge with RESET==0:
  - RSP_VALID_n=0 and RSP_RESULT_n=0.
  - Priority pointer PRI=0 (port 0 favoured).
  - While RESET==0, REQ_READY_n is forced to 0 and ALU_* are driven to 0.
  - A request or response in flight is discarded; no partial results survive reset.
- Eligibility: elig_n = REQ_VALID_n && (!RSP_VALID_n || RSP_READY_n). A slot that is being consumed can be refilled in the same cycle.
- Grant:
  - Only one port is eligible: grant that port.
  - Both ports eligible: grant port PRI.
  - No port eligible: no grant.
  - REQ_READY_n = grant_n; at most one REQ_READY is high per cycle.
- Pointer: on any grant to port n, PRI <= ~n at the edge. With no grant, PRI holds. Uncontended grants also move the pointer.
- ALU drive (combinational):
  - ALU_DATA1/ALU_DATA2/ALU_SELECT = the granted port's REQ_DATA1/REQ_DATA2/REQ_SELECT.
  - With no grant, all are 0 (ADD 0+0), so the ALU never sees X.
- Capture and latency:
  - A request accepted on edge k gives RSP_VALID_n=1 and RSP_RESULT_n=ALU_RESULT sampled at edge k.
  - The result is visible for the whole cycle after edge k: one-cycle latency.
- Response register, per port, at each edge:
  - Grant: load the new result and set VALID.
  - No grant and RSP_READY_n: clear VALID; RSP_RESULT holds its last value.
  - Otherwise: hold.
- Back-pressure: while RSP_VALID_n && !RSP_READY_n, RSP_RESULT_n is stable and port n is not granted. The other port is still served.
- Simultaneous consume and refill: full throughput of one op per cycle per port is possible when the other port is idle.
- RSP_READY_n while RSP_VALID_n==0 is ignored.
- Arithmetic: the block does no arithmetic; the result is passed bit-exact at full WIDTH.

Decomposition:
- Shared constants go in utils/macros.v: ALU_ADD=6'd0, ALU_SUB=6'd1, ALU_AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU at 6'd2..6'd9.
- One sub-module, rr_arbiter2:
  - Inputs: CLK, RESET, two elig bits.
  - Outputs: two one-hot grants.
  - Owns PRI.
- Response registers and the ALU mux stay in alu_arbiter.
- The ALU itself is instantiated outside and connected via the ALU_* ports.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with both REQ_VALID=1. Expect REQ_READY_0/1=0, RSP_VALID_0/1=0, ALU_DATA1=0. Release RESET; on the first edge port 0 is granted (PRI=0).
- Single port: port 0 issues ADD, DATA1=5, DATA2=10, RSP_READY_0=1. Expect REQ_READY_0=1 the same cycle, then RSP_VALID_0=1 and RSP_RESULT_0=15 the next cycle; port 1 outputs stay 0.
- Contention round-robin: both ports valid every cycle for 4 cycles, with port 0 issuing SUB 30-10 and port 1 issuing ADD 7+8, and both RSP_READY=1. Expect grants 0,1,0,1; RSP_RESULT_0=20 and RSP_RESULT_1=15 on alternate cycles.
- Back-pressure: port 1 completes 3+4 with RSP_READY_1=0 and re-requests continuously.
  - Expect RSP_RESULT_1=7 held stable and REQ_READY_1=0 for 3 cycles.
  - Port 0 requests are granted every cycle meanwhile.
  - When RSP_READY_1=1, port 1 is granted in the same cycle.
- Consume/refill: port 0 streams ADD i+1 for i=0..3 with RSP_READY_0 always 1. Expect REQ_READY_0=1 every cycle and results 1,2,3,4 on consecutive cycles.
- Reset mid-operation: with RSP_VALID_0=1 holding 15, assert RESET=0 for one cycle. Expect RSP_VALID_0=0 and RSP_RESULT_0=0 after that edge, and PRI=0.
